pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: address/data width; legal values are 32 or more.
REQ-002 Parameter IMM_W, default 16: branch-immediate width in the instruction; legal range 2..WIDTH.
REQ-003 Parameter RESET_PC, default 0: value loaded into PCF on reset.
REQ-004 Parameter INC, default 4: sequential fetch increment in bytes.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 StallF  in  1  hold PCF.
REQ-008 StallD  in  1  hold the F/D register.
REQ-009 FlushD  in  1  squash the F/D register contents.
REQ-010 InstrF  in  WIDTH  instruction fetched at PCF.
REQ-011 PCSrcD  in  1  decode-stage branch taken.
REQ-012 JumpD  in  1  decode-stage j/jal.
REQ-013 JrD  in  1  decode-stage jr/jalr.
REQ-014 RegD  in  WIDTH  register operand used as the jr target.
REQ-015 PCF  out  WIDTH  current fetch address.
REQ-016 PCPlus4F  out  WIDTH  PCF + INC, combinational.
REQ-017 InstrD, PCPlus4D  out  WIDTH each  F/D pipeline register outputs.
REQ-018 ValidD  out  1  F/D register holds a live instruction.
REQ-019 SignImmD  out  WIDTH  InstrD[IMM_W-1:0] sign-extended to WIDTH.
REQ-020 PCBranchD  out  WIDTH  (SignImmD << 2) + PCPlus4D, combinational.
REQ-021 PCJumpD  out  WIDTH  {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00}, combinational.

Function
REQ-022 Redirect is qualified: a redirect occurs only when ValidD=1 and StallD=0.
REQ-023 Next-PC priority when redirect is qualified: JrD selects RegD; else JumpD selects PCJumpD; else PCSrcD selects PCBranchD; else PCPlus4F.
REQ-024 PCF loads the next-PC on each edge when StallF=0 and holds its value when StallF=1; a qualified redirect is lost if StallF=1 in that cycle.
REQ-025 All additions are modulo 2^WIDTH: PCF = 2^WIDTH-INC wraps to 0, and a negative branch offset wraps without error.
REQ-026 F/D register: when FlushD=1, InstrD becomes 0, ValidD becomes 0 and PCPlus4D is held; FlushD wins over StallD.
REQ-027 F/D register: else if StallD=1, InstrD, PCPlus4D and ValidD hold their values.
REQ-028 F/D register: otherwise InstrD<=InstrF, PCPlus4D<=PCPlus4F and ValidD<=1.
REQ-029 A qualified redirect does not auto-flush; the hazard unit asserts FlushD in the same cycle.
REQ-030 Latency: PCF-to-InstrD is 1 cycle; redirect-to-PCF is 1 cycle; SignImmD, PCBranchD and PCJumpD are zero-latency from InstrD/PCPlus4D.
REQ-031 Simultaneous JrD, JumpD and PCSrcD are resolved by the REQ-023 priority only; no error is flagged.

Reset
REQ-032 On reset at a clock edge: PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0.
REQ-033 Reset overrides stall, flush and redirect in the same cycle.
REQ-034 Reset asserted mid-redirect discards the redirect; the first fetch after reset is RESET_PC.
REQ-035 Combinational outputs follow the reset register values: PCPlus4F=RESET_PC+INC, SignImmD=0, PCBranchD=0, PCJumpD=0.

Structure
REQ-036 A shared package holds the default WIDTH, IMM_W, INC and RESET_PC constants, and the next-PC select enum {SEQ, BRANCH, JUMP, JR}.
REQ-037 The F/D register is a sub-module fd_reg with enable and clear inputs; next-PC select and target arithmetic stay in pc_unit.

Verification
REQ-038 Reset then 3 idle cycles -> PCF = 0x0, 0x4, 0x8, 0xC; InstrD follows InstrF with 1 cycle delay; ValidD rises after the first edge.
REQ-039 InstrD=0x1000FFFF, PCPlus4D=0x100, PCSrcD=1, ValidD=1 -> SignImmD=0xFFFFFFFF, PCBranchD=0xFC, next PCF=0xFC.
REQ-040 JrD=1, JumpD=1 and PCSrcD=1 together, RegD=0x400 -> next PCF=0x400; with JrD=0 and InstrD=0x08000010, PCPlus4D=0x40000004 -> PCF=0x40000040.
REQ-041 StallF=StallD=1 with PCSrcD=1 for 2 cycles -> PCF, InstrD and PCPlus4D are unchanged; after the stall is released the redirect is taken.
REQ-042 FlushD=1 and StallD=1 together -> InstrD=0, ValidD=0; next cycle with PCSrcD=1 -> no redirect.
REQ-043 PCF=0xFFFFFFFC, idle -> PCF=0x0; reset asserted during a redirect cycle -> PCF=RESET_PC.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared defaults and next-PC select encoding for the fetch/decode PC logic.
package pc_unit_pkg;

    localparam int          DEF_WIDTH    = 32;
    localparam int          DEF_IMM_W    = 16;
    localparam int unsigned DEF_INC      = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEQ,
        BRANCH,
        JUMP,
        JR
    } npc_sel_e;

endpackage

// File: rtl/pc_unit_fd_reg.sv
// Fetch/decode pipeline register: clear squashes the instruction but keeps PC+INC.
module fd_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pcplus4_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pcplus4_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic             valid_q, valid_d;

    // Clear takes priority over a stalled (disabled) register.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (clr_i) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (en_i) begin
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, branch/jump target arithmetic and the F/D register.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               IMM_W    = DEF_IMM_W,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int unsigned      INC      = DEF_INC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [WIDTH-1:0] InstrF,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             JrD,
    input  logic [WIDTH-1:0] RegD,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD,
    output logic [WIDTH-1:0] SignImmD,
    output logic [WIDTH-1:0] PCBranchD,
    output logic [WIDTH-1:0] PCJumpD
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0]        pc_q, pc_d;
    logic [WIDTH-1:0]        npc;
    logic                    redirect;
    npc_sel_e                sel;
    logic signed [IMM_W-1:0] imm_s;

    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + INC_W;

    // Sized cast of a signed operand sign-extends, and stays legal when IMM_W == WIDTH.
    assign imm_s     = InstrD[IMM_W-1:0];
    assign SignImmD  = WIDTH'(imm_s);
    assign PCBranchD = (SignImmD << 2) + PCPlus4D;
    assign PCJumpD   = {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00};

    // A stalled decode stage cannot steer fetch; a bubble never redirects.
    assign redirect = ValidD && !StallD;

    always_comb begin
        sel = SEQ;
        if (redirect) begin
            if (JrD)         sel = JR;
            else if (JumpD)  sel = JUMP;
            else if (PCSrcD) sel = BRANCH;
        end
    end

    always_comb begin
        npc = PCPlus4F;
        unique case (sel)
            JR:      npc = RegD;
            JUMP:    npc = PCJumpD;
            BRANCH:  npc = PCBranchD;
            default: npc = PCPlus4F;
        endcase
    end

    assign pc_d = StallF ? pc_q : npc;

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    fd_reg #(
        .WIDTH (WIDTH)
    ) u_fd_reg (
        .clk       (clk),
        .reset     (reset),
        .en_i      (!StallD),
        .clr_i     (FlushD),
        .instr_i   (InstrF),
        .pcplus4_i (PCPlus4F),
        .instr_o   (InstrD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

endmodule
